// File: rtl/uart_pkg.sv
// Constants shared by the UART blocks: data width, register-window base and buffer mode codes.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int TX_BUF_BASE = 6;
    localparam int MODE_FRAME  = 1;
    localparam int MODE_FIFO   = 0;

endpackage

// File: rtl/tx_buf_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module tx_buf_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [PTR_W-1:0]  w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [PTR_W-1:0]  r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[w_addr] = w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign r_data = mem_q[r_addr];

endmodule

// File: rtl/tx_frame_buffer.sv
// UART transmit staging buffer: CPU writes a bus-address window, the transmitter drains in order.
// FRAME mode fills every slot by address before draining; FIFO mode is a streaming circular queue.
module tx_frame_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 3,
    parameter int BASE_ADDR  = TX_BUF_BASE,
    parameter int FRAME_MODE = MODE_FRAME
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          w_data,
    input  logic                       rd,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          r_data,
    output logic                       tx_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0]      WIN_LO    = 32'(BASE_ADDR);
    localparam logic [31:0]      WIN_HI    = 32'(BASE_ADDR + DEPTH - 1);
    localparam logic [PTR_W-1:0] BASE_LO   = PTR_W'(BASE_ADDR);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
    logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [31:0]       addr_ext;
    logic              wr_hit;
    logic [PTR_W-1:0]  slot;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              push, pop, ov_ev, un_ev;

    // Offset modulo DEPTH equals the slot index because DEPTH is a power of two.
    assign addr_ext = 32'(address);
    assign wr_hit   = wr && (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);
    assign slot     = address[PTR_W-1:0] - BASE_LO;

    tx_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (mem_we),
        .w_addr (mem_waddr),
        .w_data (w_data),
        .r_addr (r_ptr_q),
        .r_data (mem_rdata)
    );

    always_comb begin
        if (FRAME_MODE != MODE_FIFO) begin
            full     = &valid_q;
            tx_valid = full;
        end else begin
            full     = (count_q == CNT_MAX);
            tx_valid = (count_q != '0);
        end
        empty     = (count_q == '0);
        count     = count_q;
        r_data    = tx_valid ? mem_rdata : '0;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

    always_comb begin
        r_ptr_d   = r_ptr_q;
        w_ptr_d   = w_ptr_q;
        count_d   = count_q;
        valid_d   = valid_q;
        mem_we    = 1'b0;
        mem_waddr = w_ptr_q;
        push      = 1'b0;
        pop       = 1'b0;
        ov_ev     = 1'b0;
        un_ev     = 1'b0;

        if (flush) begin
            r_ptr_d = '0;
            w_ptr_d = '0;
            count_d = '0;
            valid_d = '0;
        end else if (FRAME_MODE != MODE_FIFO) begin
            un_ev = rd && !tx_valid;
            if (wr_hit) begin
                if (full) begin
                    ov_ev = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = slot;
                    if (!valid_q[slot]) begin
                        valid_d[slot] = 1'b1;
                        count_d       = count_q + CNT_W'(1);
                    end
                end
            end
            // The final pop releases the whole frame at once.
            if (rd && tx_valid) begin
                if (r_ptr_q == LAST_SLOT) begin
                    r_ptr_d = '0;
                    valid_d = '0;
                    count_d = '0;
                end else begin
                    r_ptr_d = r_ptr_q + PTR_W'(1);
                end
            end
        end else begin
            push  = wr_hit && (!full || rd);
            pop   = rd && !empty;
            ov_ev = wr_hit && full && !rd;
            un_ev = rd && empty;
            if (push) begin
                mem_we  = 1'b1;
                w_ptr_d = w_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                r_ptr_d = r_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A fresh error event outranks clr_err in the same cycle.
        overflow_d  = (overflow_q && !clr_err) || ov_ev;
        underflow_d = (underflow_q && !clr_err) || un_ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr_q     <= '0;
            w_ptr_q     <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            r_ptr_q     <= r_ptr_d;
            w_ptr_q     <= w_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer: a FRAME-mode and a FIFO-mode instance share one stimulus stream,
// checked by directed scenarios and by randomized traffic against an array/queue reference model.
module tb_tx_frame_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int BASE  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] w_data = '0;

    logic [DW-1:0] f_rdata, q_rdata;
    logic          f_txv, f_full, f_empty, f_ov, f_un;
    logic          q_txv, q_full, q_empty, q_ov, q_un;
    logic [2:0]    f_count, q_count;

    int checks = 0;
    int errors = 0;

    // Reference model: FRAME as slot array plus written flags, FIFO as a plain queue.
    logic [7:0] fmem [DEPTH];
    bit         fvalid [DEPTH];
    int         frptr;
    bit         fov, fun;
    logic [7:0] q [$];
    bit         qov, qun;

    always #5 clk = ~clk;

    tx_frame_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE), .FRAME_MODE(1)) dut_frame (
        .clk(clk), .rst_n(rst_n), .wr(wr), .address(address), .w_data(w_data), .rd(rd),
        .flush(flush), .clr_err(clr_err), .r_data(f_rdata), .tx_valid(f_txv), .full(f_full),
        .empty(f_empty), .count(f_count), .overflow(f_ov), .underflow(f_un));

    tx_frame_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE), .FRAME_MODE(0)) dut_fifo (
        .clk(clk), .rst_n(rst_n), .wr(wr), .address(address), .w_data(w_data), .rd(rd),
        .flush(flush), .clr_err(clr_err), .r_data(q_rdata), .tx_valid(q_txv), .full(q_full),
        .empty(q_empty), .count(q_count), .overflow(q_ov), .underflow(q_un));

    function automatic bit in_win(input logic [AW-1:0] a);
        return (int'(a) >= BASE) && (int'(a) <= BASE + DEPTH - 1);
    endfunction

    function automatic bit frame_full();
        for (int i = 0; i < DEPTH; i++) if (!fvalid[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_frame();
        bit ff = frame_full();
        int cnt = 0;
        for (int i = 0; i < DEPTH; i++) cnt += int'(fvalid[i]);
        return {ff ? fmem[frptr] : 8'h00, ff, ff, cnt == 0, 3'(cnt), fov, fun};
    endfunction

    function automatic logic [15:0] exp_fifo();
        int n = q.size();
        return {n > 0 ? q[0] : 8'h00, n > 0, n == DEPTH, n == 0, 3'(n), qov, qun};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            fmem[i]   = 8'h00;
            fvalid[i] = 1'b0;
        end
        frptr = 0;
        fov = 1'b0; fun = 1'b0;
        q.delete();
        qov = 1'b0; qun = 1'b0;
    endtask

    task automatic model_update(input logic w, input logic [AW-1:0] a, input logic [7:0] d,
                                input logic r, input logic f, input logic c);
        bit hit = w && in_win(a);
        bit ffull = frame_full();
        int qsize = q.size();
        bit ev_fo = 1'b0, ev_fu = 1'b0, ev_qo = 1'b0, ev_qu = 1'b0;
        if (f) begin
            for (int i = 0; i < DEPTH; i++) fvalid[i] = 1'b0;
            frptr = 0;
            q.delete();
        end else begin
            if (hit && ffull) ev_fo = 1'b1;
            else if (hit) begin
                fmem[int'(a) - BASE]   = d;
                fvalid[int'(a) - BASE] = 1'b1;
            end
            if (r && !ffull) ev_fu = 1'b1;
            else if (r) begin
                if (frptr == DEPTH - 1) begin
                    for (int i = 0; i < DEPTH; i++) fvalid[i] = 1'b0;
                    frptr = 0;
                end else frptr++;
            end
            if (r && qsize == 0) ev_qu = 1'b1;
            else if (r) void'(q.pop_front());
            if (hit) begin
                if (qsize == DEPTH && !r) ev_qo = 1'b1;
                else q.push_back(d);
            end
        end
        fov = (fov && !c) || ev_fo;
        fun = (fun && !c) || ev_fu;
        qov = (qov && !c) || ev_qo;
        qun = (qun && !c) || ev_qu;
    endtask

    task automatic step(input logic w, input logic [AW-1:0] a, input logic [7:0] d,
                        input logic r, input logic f, input logic c);
        wr = w; address = a; w_data = d; rd = r; flush = f; clr_err = c;
        @(posedge clk);
        model_update(w, a, d, r, f, c);
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({f_rdata, f_txv, f_full, f_empty, f_count, f_ov, f_un} !== 16'h0020) begin
            errors++; $display("[TB] FAIL reset_frame got %h want 0020", {f_rdata, f_txv, f_full, f_empty, f_count, f_ov, f_un});
        end
        checks++;
        if ({q_rdata, q_txv, q_full, q_empty, q_count, q_ov, q_un} !== 16'h0020) begin
            errors++; $display("[TB] FAIL reset_fifo got %h want 0020", {q_rdata, q_txv, q_full, q_empty, q_count, q_ov, q_un});
        end
    endtask

    task automatic test_frame_fill_drain();
        logic [7:0] exp_words [3] = '{8'hA2, 8'hA3, 8'hA4};
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(BASE + i), 8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
        checks++;
        if ({f_full, f_count, f_rdata} !== {1'b1, 3'd4, 8'hA1}) begin
            errors++; $display("[TB] FAIL fill full/count/rdata got %b/%0d/%h want 1/4/a1", f_full, f_count, f_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (f_rdata !== exp_words[i]) begin
                errors++; $display("[TB] FAIL drain_%0d got %h want %h", i, f_rdata, exp_words[i]);
            end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({f_full, f_empty, f_count, f_rdata} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
            errors++; $display("[TB] FAIL last_rd full/empty/count/rdata got %b/%b/%0d/%h want 0/1/0/00", f_full, f_empty, f_count, f_rdata);
        end
    endtask

    task automatic test_frame_rewrite();
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (f_count !== 3'd0 || q_count !== 3'd0) begin
            errors++; $display("[TB] FAIL flush counts got %0d/%0d want 0/0", f_count, q_count);
        end
        step(1'b1, 4'd6, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd6, 8'h22, 1'b0, 1'b0, 1'b0);
        checks++;
        if (f_count !== 3'd1) begin
            errors++; $display("[TB] FAIL rewrite_count got %0d want 1", f_count);
        end
        step(1'b1, 4'd7, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd8, 8'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd9, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({f_full, f_rdata} !== {1'b1, 8'h22}) begin
            errors++; $display("[TB] FAIL rewrite_head full/rdata got %b/%h want 1/22", f_full, f_rdata);
        end
    endtask

    task automatic test_frame_overflow();
        step(1'b1, 4'd7, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({f_ov, f_count, f_rdata} !== {1'b1, 3'd4, 8'h22}) begin
            errors++; $display("[TB] FAIL ovf ov/count/rdata got %b/%0d/%h want 1/4/22", f_ov, f_count, f_rdata);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (f_rdata !== 8'h33) begin
            errors++; $display("[TB] FAIL ovf_kept_slot got %h want 33", f_rdata);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (f_ov !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_err got %b want 0", f_ov);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd6, 8'h77, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({f_ov, f_count, f_empty} !== {1'b1, 3'd0, 1'b1}) begin
            errors++; $display("[TB] FAIL final_rd_wr ov/count/empty got %b/%0d/%b want 1/0/1", f_ov, f_count, f_empty);
        end
    endtask

    task automatic test_fifo_order();
        logic [3:0] addrs [4] = '{4'd9, 4'd6, 4'd7, 4'd8};
        logic [7:0] drain [4] = '{8'h20, 8'h30, 8'h40, 8'h60};
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, addrs[i], 8'(8'h10 * (i + 1)), 1'b0, 1'b0, 1'b0);
        checks++;
        if ({q_full, q_count, q_rdata} !== {1'b1, 3'd4, 8'h10}) begin
            errors++; $display("[TB] FAIL fifo_fill full/count/rdata got %b/%0d/%h want 1/4/10", q_full, q_count, q_rdata);
        end
        step(1'b1, 4'd6, 8'h50, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({q_ov, q_count} !== {1'b1, 3'd4}) begin
            errors++; $display("[TB] FAIL fifo_ovf ov/count got %b/%0d want 1/4", q_ov, q_count);
        end
        step(1'b1, 4'd7, 8'h60, 1'b1, 1'b0, 1'b0);
        checks++;
        if (q_count !== 3'd4) begin
            errors++; $display("[TB] FAIL fifo_wr_rd_full count got %0d want 4", q_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_rdata !== drain[i]) begin
                errors++; $display("[TB] FAIL fifo_drain_%0d got %h want %h", i, q_rdata, drain[i]);
            end
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if ({q_empty, q_count, q_un} !== {1'b1, 3'd0, 1'b0}) begin
            errors++; $display("[TB] FAIL fifo_drained empty/count/un got %b/%0d/%b want 1/0/0", q_empty, q_count, q_un);
        end
    endtask

    task automatic test_fifo_underflow();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({q_un, q_count, q_rdata} !== {1'b1, 3'd0, 8'h00}) begin
            errors++; $display("[TB] FAIL fifo_unf un/count/rdata got %b/%0d/%h want 1/0/00", q_un, q_count, q_rdata);
        end
        step(1'b1, 4'd5, 8'h99, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd10, 8'h98, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({q_count, q_empty, q_ov} !== {3'd0, 1'b1, 1'b0}) begin
            errors++; $display("[TB] FAIL out_of_window count/empty/ov got %0d/%b/%b want 0/1/0", q_count, q_empty, q_ov);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] words [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            words[i] = 8'($urandom);
            step(1'b1, AW'(BASE + i), words[i], 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (f_rdata !== words[2]) begin
            errors++; $display("[TB] FAIL pre_reset_head got %h want %h", f_rdata, words[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({f_rdata, f_txv, f_full, f_empty, f_count, f_ov, f_un} !== 16'h0020) begin
            errors++; $display("[TB] FAIL async_reset got %h want 0020", {f_rdata, f_txv, f_full, f_empty, f_count, f_ov, f_un});
        end
        model_reset();
        #2 rst_n = 1'b1;
        step(1'b1, 4'd6, 8'h5A, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({f_count, f_full, f_ov} !== {3'd1, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL post_reset_wr count/full/ov got %0d/%b/%b want 1/0/0", f_count, f_full, f_ov);
        end
    endtask

    task automatic test_random();
        logic w, r, f, c;
        logic [AW-1:0] a;
        logic [15:0] ef, eq;
        for (int n = 0; n < 600; n++) begin
            f = ($urandom_range(0, 99) < 3);
            c = !f && ($urandom_range(0, 99) < 5);
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 40);
            a = AW'($urandom_range(4, 11));
            step(w, a, 8'($urandom), r, f, c);
            ef = exp_frame();
            eq = exp_fifo();
            checks++;
            if ({f_rdata, f_txv, f_full, f_empty, f_count, f_ov, f_un} !== ef) begin
                errors++; $display("[TB] FAIL rand_frame cycle %0d got %h want %h", n, {f_rdata, f_txv, f_full, f_empty, f_count, f_ov, f_un}, ef);
            end
            checks++;
            if ({q_rdata, q_txv, q_full, q_empty, q_count, q_ov, q_un} !== eq) begin
                errors++; $display("[TB] FAIL rand_fifo cycle %0d got %h want %h", n, {q_rdata, q_txv, q_full, q_empty, q_count, q_ov, q_un}, eq);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_frame_fill_drain();
        test_frame_rewrite();
        test_frame_overflow();
        test_fifo_order();
        test_fifo_underflow();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
